// File: rtl/memory_pkg.sv
// Shared constants and helpers for the data_memory block and its valid tracker.
package memory_pkg;

  localparam int DATAIN_W = 20;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 256;

  function automatic int addr_width(input int n_words);
    return $clog2(n_words);
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Address/write-enable bus between a requester (master) and data_memory (slave).
interface data_memory_if
  import memory_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int depth = DEPTH
);

  logic [addr_width(depth)-1:0] address;
  logic [DATAIN_W-1:0]          datain;
  logic                         write_en;
  logic [width-1:0]             data_out;
  logic                         full;

  modport master (
    output address,
    output datain,
    output write_en,
    input  data_out,
    input  full
  );

  modport slave (
    input  address,
    input  datain,
    input  write_en,
    output data_out,
    output full
  );

endinterface

// File: rtl/memory_valid_tracker.sv
// Per-entry valid bits plus a saturating count of written entries; drives full.
module memory_valid_tracker
  import memory_pkg::*;
#(
  parameter int depth = DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [addr_width(depth)-1:0] address,
  input  logic                         write_en,
  output logic                         entry_valid,
  output logic                         full
);

  localparam int CW = addr_width(depth) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(depth);

  logic [depth-1:0] valid_bits;
  logic [CW-1:0]    valid_count;

  // Only a first write to an entry grows the count; rewrites leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_bits  <= '0;
      valid_count <= '0;
    end else if (write_en && !valid_bits[address]) begin
      valid_bits[address] <= 1'b1;
      if (valid_count != FULL_COUNT)
        valid_count <= valid_count + CW'(1);
    end
  end

  assign entry_valid = valid_bits[address];
  assign full        = (valid_count == FULL_COUNT);

endmodule

// File: rtl/data_memory.sv
// Single-port RAM with registered read; unwritten entries read as zero.
// Define MEMORY_BYPASS_EN for write-through on same-address read/write.
module data_memory
  import memory_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int depth = DEPTH
) (
  input logic          clk,
  input logic          rst,
  data_memory_if.slave bus
);

  logic [width-1:0] mem [depth];
  logic [width-1:0] write_word;
  logic [width-1:0] read_word;
  logic [width-1:0] data_q;
  logic             entry_valid;
  logic             full;

  memory_valid_tracker #(
    .depth(depth)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .address    (bus.address),
    .write_en   (bus.write_en),
    .entry_valid(entry_valid),
    .full       (full)
  );

  assign write_word = width'(bus.datain);

  // RAM contents are never reset; the cleared valid bits hide stale words.
  always_ff @(posedge clk) begin
    if (bus.write_en)
      mem[bus.address] <= write_word;
  end

  always_comb begin
    read_word = entry_valid ? mem[bus.address] : '0;
`ifdef MEMORY_BYPASS_EN
    if (bus.write_en)
      read_word = write_word;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      data_q <= '0;
    else
      data_q <= read_word;
  end

  assign bus.data_out = data_q;
  assign bus.full     = full;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against an array-based reference model.
module tb_data_memory;
  import memory_pkg::*;

  localparam int W = 32;
  localparam int D = 256;
`ifdef MEMORY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_if #(.width(W), .depth(D)) bus ();

  data_memory #(.width(W), .depth(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0] ref_mem   [D];
  bit           ref_valid [D];
  int compared   = 0;
  int mismatched = 0;

  function automatic int refCount();
    int n = 0;
    for (int i = 0; i < D; i++) n += ref_valid[i] ? 1 : 0;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] exp_data, input logic exp_full);
    compared++;
    assert (bus.data_out === exp_data) else begin
      mismatched++;
      $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, bus.data_out, exp_data);
    end
    compared++;
    assert (bus.full === exp_full) else begin
      mismatched++;
      $error("[TB] FAIL %s full observed=%b expected=%b", tag, bus.full, exp_full);
    end
  endtask

  // One bus access: drive on the falling edge, model the rising edge, check 1 time unit later.
  task automatic applyStimulus(input int addr, input logic [19:0] data, input logic we, input string tag);
    logic [W-1:0] exp_data;
    @(negedge clk);
    bus.address  = addr[7:0];
    bus.datain   = data;
    bus.write_en = we;
    @(posedge clk);
    if (BYPASS && we) exp_data = W'(data);
    else              exp_data = ref_valid[addr] ? ref_mem[addr] : '0;
    if (we) begin
      ref_mem[addr]   = W'(data);
      ref_valid[addr] = 1'b1;
    end
    #1 checkOutput(tag, exp_data, refCount() == D);
  endtask

  // Reset asserted between edges with a write pending; outputs must clear at once.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    bus.address  = 8'd5;
    bus.datain   = 20'h5A5A5;
    bus.write_en = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < D; i++) ref_valid[i] = 1'b0;
    #1 checkOutput(tag, '0, 1'b0);
    @(negedge clk);
    bus.write_en = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin
      ref_mem[i]   = '0;
      ref_valid[i] = 1'b0;
    end
    bus.address  = '0;
    bus.datain   = '0;
    bus.write_en = 1'b0;

    #2 rst = 1'b0;
    #1 checkOutput("reset_init", '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] reset released");

    applyStimulus(200, 20'h0, 1'b0, "read_unwritten_200");
    applyStimulus(8, 20'hABCDE, 1'b1, "write_8");
    applyStimulus(8, 20'h0, 1'b0, "read_8");
    compared++;
    assert (bus.data_out === 32'h000ABCDE) else begin
      mismatched++;
      $error("[TB] FAIL read_8_const data_out observed=%h expected=%h", bus.data_out, 32'h000ABCDE);
    end

    applyStimulus(10, 20'h12345, 1'b1, "collision_10");
    applyStimulus(10, 20'h0, 1'b0, "read_after_collision_10");

    $display("[TB] random phase");
    for (int k = 0; k < 300; k++) begin
      int a;
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, D - 1));
      applyStimulus(a, 20'($urandom), 1'($urandom_range(0, 1)), "random_op");
    end

    pulseReset("async_reset_mid_run");
    applyStimulus(5, 20'h0, 1'b0, "read_5_after_reset");

    $display("[TB] fill phase");
    for (int a = 0; a < D - 1; a++)
      applyStimulus(a, 20'($urandom), 1'b1, "fill_write");
    compared++;
    assert (bus.full === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL full_before_last observed=%b expected=%b", bus.full, 1'b0);
    end
    applyStimulus(D - 1, 20'hFEDCB, 1'b1, "fill_last_255");
    applyStimulus(3, 20'h33333, 1'b1, "rewrite_3_full");
    applyStimulus(3, 20'h0, 1'b0, "read_3_full");
    for (int k = 0; k < 40; k++)
      applyStimulus(int'($urandom_range(0, D - 1)), 20'($urandom), 1'($urandom_range(0, 1)), "random_full");

    pulseReset("async_reset_after_fill");
    applyStimulus(0, 20'h0, 1'b0, "read_0_after_fill_reset");
    applyStimulus(0, 20'h00F0F, 1'b1, "rewrite_0");
    applyStimulus(0, 20'h0, 1'b0, "read_0_rewritten");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
